// File: rtl/rf_pkg.sv
// Shared register-file constants used by the write-port arbiter and its neighbours.
package rf_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 32;
    localparam int ZERO_REG  = 0;

    localparam int SRC_ALU  = 0;
    localparam int SRC_LOAD = 1;
    localparam int SRC_CSR  = 2;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set bit of valid at or after ptr, wrapping mod N.
module rr_pick #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        // ptr is always < N, so the modulo keeps the scan inside the vector.
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && valid[j]) begin
                grant[j] = 1'b1;
                idx      = PTR_W'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wp_arbiter.sv
// Round-robin arbiter sharing the register-file write port between writeback
// sources; registers the winner onto WE/WA/WD and publishes a pending-write mask.
module rf_wp_arbiter
    import rf_pkg::*;
#(
    parameter int N_SRC  = 3,
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hold,
    input  logic [N_SRC-1:0]          req_valid,
    input  logic [N_SRC*ADDR_W-1:0]   req_addr,
    input  logic [N_SRC*DATA_W-1:0]   req_data,
    output logic [N_SRC-1:0]          req_ready,
    output logic                      WE,
    output logic [ADDR_W-1:0]         WA,
    output logic [DATA_W-1:0]         WD,
    output logic [(2**ADDR_W)-1:0]    pend
);

    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int DEPTH = 2**ADDR_W;

    // Handshake: a source presents valid/addr/data and holds them stable; the
    // write transfers in the cycle where valid && ready, ready is one-hot or zero.
    logic [PTR_W-1:0]  ptr;
    logic [N_SRC-1:0]  elig;
    logic [PTR_W-1:0]  gidx;
    logic              gany;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_data;
    logic [PTR_W-1:0]  ptr_next;

    assign elig = hold ? '0 : req_valid;

    rr_pick #(
        .N     (N_SRC),
        .PTR_W (PTR_W)
    ) u_pick (
        .valid (elig),
        .ptr   (ptr),
        .grant (req_ready),
        .idx   (gidx),
        .any   (gany)
    );

    assign g_addr   = req_addr[int'(gidx)*ADDR_W +: ADDR_W];
    assign g_data   = req_data[int'(gidx)*DATA_W +: DATA_W];
    assign ptr_next = (gidx == PTR_W'(N_SRC - 1)) ? '0 : gidx + PTR_W'(1);

    // x0 writes are consumed like any other grant but never raise WE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            WE  <= 1'b0;
            WA  <= '0;
            WD  <= '0;
        end else if (gany) begin
            ptr <= ptr_next;
            WA  <= g_addr;
            WD  <= g_data;
            WE  <= (g_addr != ADDR_W'(ZERO_REG));
        end else begin
            WE  <= 1'b0;
        end
    end

    always_comb begin
        pend = '0;
        for (int r = 1; r < DEPTH; r++) begin
            if (WE && (WA == ADDR_W'(r))) begin
                pend[r] = 1'b1;
            end
            for (int i = 0; i < N_SRC; i++) begin
                if (req_valid[i] && (req_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                    pend[r] = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_wp_arbiter.sv
// Directed bench for rf_wp_arbiter with a behavioural register-file model.
module tb_rf_wp_arbiter;

    localparam int N_SRC  = 3;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic                    clk;
    logic                    rst;
    logic                    hold;
    logic [N_SRC-1:0]        req_valid;
    logic [N_SRC*ADDR_W-1:0] req_addr;
    logic [N_SRC*DATA_W-1:0] req_data;
    logic [N_SRC-1:0]        req_ready;
    logic                    WE;
    logic [ADDR_W-1:0]       WA;
    logic [DATA_W-1:0]       WD;
    logic [31:0]             pend;

    int errors;
    int checks;
    logic [ADDR_W-1:0] exp_q[$];
    logic [DATA_W-1:0] rf_model[32];

    rf_wp_arbiter #(
        .N_SRC  (N_SRC),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .WE        (WE),
        .WA        (WA),
        .WD        (WD),
        .pend      (pend)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register file captures the staged write at the end of the WE cycle
    initial begin
        for (int r = 0; r < 32; r++) rf_model[r] = '0;
    end
    always @(posedge clk) begin
        if (WE) rf_model[WA] <= WD;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        req_valid[i]                 = v;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
    endtask

    initial begin
        logic [ADDR_W-1:0] exp_wa;
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        hold   = 1'b0;
        clear_reqs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset_we", 64'(WE), 64'd0);
        check("reset_wa", 64'(WA), 64'd0);
        check("reset_wd", 64'(WD), 64'd0);
        check("reset_pend", 64'(pend), 64'd0);

        // round-robin fairness, first grant after reset goes to source 0
        set_req(0, 1'b1, 5'd2, 32'd20);
        set_req(1, 1'b1, 5'd3, 32'd30);
        set_req(2, 1'b1, 5'd4, 32'd40);
        #1;
        check("rr_pend", 64'(pend), 64'h1c);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("rr_ready%0d", k), 64'(req_ready), 64'(3'b001 << (k % 3)));
            exp_q.push_back(ADDR_W'(2 + (k % 3)));
            tick();
            exp_wa = exp_q.pop_front();
            check($sformatf("rr_we%0d", k), 64'(WE), 64'd1);
            check($sformatf("rr_wa%0d", k), 64'(WA), 64'(exp_wa));
            check($sformatf("rr_wd%0d", k), 64'(WD), 64'(exp_wa) * 64'd10);
        end
        clear_reqs();
        tick();
        check("rr_idle_we", 64'(WE), 64'd0);

        // single write from source 1
        set_req(1, 1'b1, 5'd1, 32'd10);
        #1;
        check("single_ready", 64'(req_ready), 64'b010);
        check("single_pend_t", 64'(pend), 64'h2);
        tick();
        clear_reqs();
        #1;
        check("single_we", 64'(WE), 64'd1);
        check("single_wa", 64'(WA), 64'd1);
        check("single_wd", 64'(WD), 64'd10);
        check("single_pend_t1", 64'(pend), 64'h2);
        tick();
        check("single_we_off", 64'(WE), 64'd0);
        check("single_rf1", 64'(rf_model[1]), 64'd10);

        // x0 write: ptr is 2, source 0 wins, consumed without WE
        set_req(0, 1'b1, 5'd0, 32'd11);
        #1;
        check("x0_ready", 64'(req_ready), 64'b001);
        check("x0_pend", 64'(pend), 64'd0);
        tick();
        clear_reqs();
        #1;
        check("x0_we", 64'(WE), 64'd0);
        check("x0_pend_t1", 64'(pend), 64'd0);
        set_req(0, 1'b1, 5'd6, 32'd60);
        set_req(1, 1'b1, 5'd7, 32'd70);
        #1;
        check("x0_ptr_adv", 64'(req_ready), 64'b010);
        tick();
        clear_reqs();
        #1;
        check("x0_next_wa", 64'(WA), 64'd7);
        check("x0_rf0", 64'(rf_model[0]), 64'd0);

        // same-address conflict with ptr at 2
        set_req(0, 1'b1, 5'd5, 32'd1);
        set_req(2, 1'b1, 5'd5, 32'd2);
        #1;
        check("conf_ready_a", 64'(req_ready), 64'b100);
        tick();
        set_req(2, 1'b0, 5'd0, 32'd0);
        #1;
        check("conf_wd_a", 64'(WD), 64'd2);
        check("conf_ready_b", 64'(req_ready), 64'b001);
        tick();
        clear_reqs();
        #1;
        check("conf_wd_b", 64'(WD), 64'd1);
        tick();
        check("conf_rf5", 64'(rf_model[5]), 64'd1);

        // hold with a staged write: ptr is 1
        set_req(1, 1'b1, 5'd8, 32'd80);
        #1;
        check("hold_pre_ready", 64'(req_ready), 64'b010);
        tick();
        set_req(1, 1'b1, 5'd9, 32'd90);
        hold = 1'b1;
        #1;
        check("hold_ready", 64'(req_ready), 64'd0);
        check("hold_we_retire", 64'(WE), 64'd1);
        check("hold_pend", 64'(pend), 64'h300);
        tick();
        check("hold_we_once", 64'(WE), 64'd0);
        check("hold_ready2", 64'(req_ready), 64'd0);
        set_req(0, 1'b1, 5'd12, 32'd120);
        set_req(2, 1'b1, 5'd10, 32'd100);
        hold = 1'b0;
        #1;
        check("hold_resume", 64'(req_ready), 64'b100);
        tick();
        clear_reqs();
        #1;
        check("rst_pre_we", 64'(WE), 64'd1);
        check("rst_pre_wa", 64'(WA), 64'd10);

        // asynchronous reset while a write is staged
        #2 rst = 1'b1;
        #1;
        check("rst_async_we", 64'(WE), 64'd0);
        check("rst_async_wa", 64'(WA), 64'd0);
        check("rst_async_wd", 64'(WD), 64'd0);
        check("rst_async_pend", 64'(pend), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_rf10", 64'(rf_model[10]), 64'd0);
        set_req(0, 1'b1, 5'd2, 32'd1);
        set_req(1, 1'b1, 5'd3, 32'd2);
        set_req(2, 1'b1, 5'd4, 32'd3);
        #1;
        check("rst_first_grant", 64'(req_ready), 64'b001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
